// File: rtl/vendor_change_dispenser_if.sv
// Refund request and coin-ejector handshake bundle for the change dispenser.
// master: vending controller / ejector / refill side; slave: the dispenser.
interface vendor_change_dispenser_if #(
   parameter int MONEY_W = 9
);
   logic               start;
   logic [MONEY_W-1:0] amount;
   logic               busy;
   logic               coin_valid;
   logic [1:0]         coin;
   logic               coin_ack;
   logic               done;
   logic               short;
   logic [MONEY_W-1:0] remaining;
   logic               refill;
   logic [1:0]         refill_coin;
   logic [3:0]         stock_empty;

   modport master (
      output start, amount, coin_ack, refill, refill_coin,
      input  busy, coin_valid, coin, done, short, remaining, stock_empty
   );

   modport slave (
      input  start, amount, coin_ack, refill, refill_coin,
      output busy, coin_valid, coin, done, short, remaining, stock_empty
   );
endinterface

// File: rtl/vendor_change_dispenser.sv
// Change/refund dispenser: pays a refund amount greedily (largest coin first),
// one coin per ejector handshake, tracking per-denomination stock.
// Coin encoding: 0=10, 1=20, 2=50, 3=100.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; amount latched into remaining on start
// S_SELECT | one cycle: pick largest affordable coin in stock, or finish
// S_EJECT  | coin_valid held with stable coin until coin_ack
// S_FINISH | one cycle: done pulse, short captured from remaining
module vendor_change_dispenser #(
   parameter int MONEY_W    = 9,
   parameter int STOCK_W    = 4,
   parameter int INIT_STOCK = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_ni,
   vendor_change_dispenser_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SELECT = 2'd1,
      S_EJECT  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   localparam logic [STOCK_W-1:0] STOCK_MAX  = '1;
   localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

   state_t               state_q, state_d;
   logic [MONEY_W-1:0]   remaining_q, remaining_d;
   logic [1:0]           coin_q, coin_d;
   logic                 coin_valid_q, coin_valid_d;
   logic                 short_q, short_d;
   logic [STOCK_W-1:0]   stock_q [4];
   logic [STOCK_W-1:0]   stock_d [4];

   logic                 pick_ok;
   logic [1:0]           pick_coin;
   logic                 eject_take;

   function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] d);
      case (d)
         2'd0:    coin_value = MONEY_W'(10);
         2'd1:    coin_value = MONEY_W'(20);
         2'd2:    coin_value = MONEY_W'(50);
         default: coin_value = MONEY_W'(100);
      endcase
   endfunction

   // Greedy pick: ascending scan so the largest eligible denomination wins.
   always_comb begin
      pick_ok   = 1'b0;
      pick_coin = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if ((coin_value(2'(i)) <= remaining_q) && (stock_q[i] != '0)) begin
            pick_ok   = 1'b1;
            pick_coin = 2'(i);
         end
      end
   end

   assign eject_take = (state_q == S_EJECT) && bus.coin_ack;

   // Next-state and datapath updates for the payout sequence.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      coin_d       = coin_q;
      coin_valid_d = coin_valid_q;
      short_d      = short_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               remaining_d = bus.amount;
               short_d     = 1'b0;
               state_d     = S_SELECT;
            end
         end
         S_SELECT: begin
            if (pick_ok) begin
               coin_d       = pick_coin;
               coin_valid_d = 1'b1;
               state_d      = S_EJECT;
            end else begin
               state_d = S_FINISH;
            end
         end
         S_EJECT: begin
            if (bus.coin_ack) begin
               coin_valid_d = 1'b0;
               // Cannot underflow: the coin was only chosen if value <= remaining.
               remaining_d  = remaining_q - coin_value(coin_q);
               state_d      = S_SELECT;
            end
         end
         S_FINISH: begin
            short_d = (remaining_q != '0);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stock bookkeeping: refill saturates, acked eject decrements, both cancel.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         stock_d[i] = stock_q[i];
         if (bus.refill && (bus.refill_coin == 2'(i))) begin
            if (!(eject_take && (coin_q == 2'(i)))) begin
               if (stock_q[i] != STOCK_MAX) begin
                  stock_d[i] = stock_q[i] + 1'b1;
               end
            end
         end else if (eject_take && (coin_q == 2'(i))) begin
            stock_d[i] = stock_q[i] - 1'b1;
         end
      end
   end

   // State, datapath and stock registers; reset abandons any payout at once.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= S_IDLE;
         remaining_q  <= '0;
         coin_q       <= 2'd0;
         coin_valid_q <= 1'b0;
         short_q      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            stock_q[i] <= STOCK_INIT;
         end
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         coin_q       <= coin_d;
         coin_valid_q <= coin_valid_d;
         short_q      <= short_d;
         for (int i = 0; i < 4; i++) begin
            stock_q[i] <= stock_d[i];
         end
      end
   end

   // Empty flags decoded straight from the stock counters.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         bus.stock_empty[i] = (stock_q[i] == '0);
      end
   end

   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_FINISH);
   assign bus.coin_valid = coin_valid_q;
   assign bus.coin       = coin_q;
   assign bus.short      = short_q;
   assign bus.remaining  = remaining_q;

endmodule

// File: doc/vendor_change_dispenser.md
Name: vendor_change_dispenser

Overview:
- Change/refund path of the vending machine: the outgoing counterpart of the coin-acceptor side.
- Takes a refund amount from the vending controller and pays it out as physical coins, one coin per handshake with the coin-ejector mechanism.
- Uses the same coin encoding as the acceptor: 0=10, 1=20, 2=50, 3=100.
- Pays greedily (largest coin first), tracks per-denomination coin stock and reports any unpaid remainder.

Parameters:
- MONEY_W, 9, width of amount/remaining in money units.
- STOCK_W, 4, width of each per-denomination stock counter.
- INIT_STOCK, 4, stock value loaded into every denomination on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to pay out amount; sampled only in IDLE.
- amount  input  MONEY_W  refund value; latched on accepted start.
- busy  output  1  high in every state except IDLE.
- coin_valid  output  1  ejector request; coin is valid while high.
- coin  output  2  denomination to eject (0=10, 1=20, 2=50, 3=100).
- coin_ack  input  1  ejector has released the coin; meaningful only while coin_valid=1.
- done  output  1  one-cycle pulse at the end of a payout.
- short  output  1  payout ended with remaining != 0; held until the next accepted start.
- remaining  output  MONEY_W  amount still owed; live value.
- refill  input  1  adds one coin of refill_coin to stock this cycle.
- refill_coin  input  2  denomination being refilled.
- stock_empty  output  4  bit i = stock of denomination i is 0.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE.
  - coin_valid=0, coin=0, done=0, short=0, busy=0, remaining=0.
  - all stocks=INIT_STOCK, so stock_empty=0 when INIT_STOCK>0.
  - Assertion mid-payout drops coin_valid immediately. The payout is abandoned, with no done pulse.
- States: IDLE, SELECT, EJECT, FINISH.
- IDLE:
  - start=1 latches remaining<=amount, clears short, moves to SELECT next cycle.
  - start seen outside IDLE is ignored, with no queuing.
- SELECT (exactly one cycle):
  - Pick the largest denomination d with value(d) <= remaining and stock[d] > 0.
  - If one exists: coin<=d, coin_valid<=1, go to EJECT.
  - Otherwise go to FINISH.
- EJECT:
  - coin and coin_valid stay stable until coin_ack=1 is sampled.
  - On that edge: coin_valid<=0, remaining<=remaining-value(d), stock[d]<=stock[d]-1, back to SELECT.
  - So minimum cost is 2 cycles per coin. coin_ack outside EJECT is ignored.
- FINISH (one cycle): done=1, short<=(remaining!=0), then IDLE. remaining keeps its final value.
- Latency:
  - start to first coin_valid = 2 cycles.
  - amount=0 gives done 2 cycles after start (IDLE to SELECT to FINISH), short=0.
- Arithmetic:
  - Comparisons are unsigned at MONEY_W bits.
  - Subtraction never underflows, because a coin is selected only when value <= remaining.
  - An amount that is not a multiple of 10 leaves a residue below 10, which gives short=1.
- Stock:
  - refill increments stock[refill_coin], saturating at 2^STOCK_W-1.
  - refill and an acked eject of the same denomination in the same cycle leave the stock unchanged (net 0).
  - refill is accepted in any state. A refill that lands in SELECT is visible to the following SELECT.
- stock_empty is combinational from the stock counters.

Test Plan:
- Reset, start with amount=180, all stocks=4, ack one cycle after each coin_valid -> coins in order 3,2,1,0 (100,50,20,10); done pulse; short=0; remaining=0; stocks 3,3,3,3.
- amount=0 -> no coin_valid, done exactly 2 cycles after start, short=0.
- Stock of 50 and 20 set to 0 (eject down via prior payouts), amount=60 -> coins 0 x4 (10 each) while stock lasts, then the 100 path is skipped; with stock[0]=4, ends with remaining=20, short=1.
- amount=35 -> coins 1,0 (20,10), remaining=5, short=1, done pulse.
- Hold coin_ack=0 for 10 cycles during EJECT -> coin and coin_valid stable throughout; start pulses during busy are ignored; a late ack completes normally.
- Assert reset (low) while coin_valid=1 -> coin_valid=0 asynchronously, busy=0, stocks back to INIT_STOCK; refill on denomination 3 with a same-cycle ack of coin 3 -> stock[3] unchanged.
